// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous word memory between the instruction-fetch
// port and the data load/store port. Define ROUND_ROBIN_EN for alternating priority under contention.
module mem_arbiter #(
    parameter int W          = 32,
    parameter int D          = 8,
    parameter int STARVE_MAX = 3
) (
    input  logic         i_clk,
    input  logic         i_reset,

    input  logic         i_if_req,
    input  logic [D-1:0] i_if_addr,
    output logic         o_if_gnt,
    output logic         o_if_rvalid,
    output logic [W-1:0] o_if_rdata,

    input  logic         i_dm_req,
    input  logic         i_dm_we,
    input  logic [D-1:0] i_dm_addr,
    input  logic [W-1:0] i_dm_wdata,
    output logic         o_dm_gnt,
    output logic         o_dm_rvalid,
    output logic [W-1:0] o_dm_rdata,

    output logic [D-1:0] o_mem_addr,
    output logic [W-1:0] o_mem_data,
    output logic         o_mem_read,
    output logic         o_mem_write,
    input  logic [W-1:0] i_mem_data
);

    typedef enum logic [1:0] {
        RD_NONE,
        RD_FETCH,
        RD_DATA
    } rd_owner_t;

    rd_owner_t rd_owner;
    rd_owner_t rd_owner_next;
    logic      if_gnt;
    logic      dm_gnt;

`ifdef ROUND_ROBIN_EN
    typedef enum logic {
        LAST_DATA,
        LAST_FETCH
    } last_grant_t;

    last_grant_t last_grant;
    last_grant_t last_grant_next;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            last_grant <= LAST_DATA;
        end else begin
            last_grant <= last_grant_next;
        end
    end

    always_comb begin
        last_grant_next = last_grant;
        if (if_gnt) begin
            last_grant_next = LAST_FETCH;
        end else if (dm_gnt) begin
            last_grant_next = LAST_DATA;
        end
    end

    // Under contention the port that did not win last time goes first.
    always_comb begin
        if_gnt = 1'b0;
        dm_gnt = 1'b0;
        if (!i_reset) begin
            if (i_if_req && i_dm_req) begin
                if (last_grant == LAST_DATA) begin
                    if_gnt = 1'b1;
                end else begin
                    dm_gnt = 1'b1;
                end
            end else begin
                if_gnt = i_if_req;
                dm_gnt = i_dm_req;
            end
        end
    end
`else
    localparam logic [3:0] STARVE_LIMIT = 4'(STARVE_MAX);

    logic [3:0] starve_cnt;
    logic [3:0] starve_cnt_next;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            starve_cnt <= '0;
        end else begin
            starve_cnt <= starve_cnt_next;
        end
    end

    // Counts data wins that left fetch waiting; saturates at the limit.
    always_comb begin
        starve_cnt_next = starve_cnt;
        if (!i_if_req || if_gnt) begin
            starve_cnt_next = '0;
        end else if (dm_gnt && (starve_cnt != STARVE_LIMIT)) begin
            starve_cnt_next = starve_cnt + 4'd1;
        end
    end

    always_comb begin
        if_gnt = 1'b0;
        dm_gnt = 1'b0;
        if (!i_reset) begin
            if (i_if_req && (starve_cnt == STARVE_LIMIT)) begin
                if_gnt = 1'b1;
            end else if (i_dm_req) begin
                dm_gnt = 1'b1;
            end else if (i_if_req) begin
                if_gnt = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        o_mem_addr  = '0;
        o_mem_data  = '0;
        o_mem_read  = 1'b0;
        o_mem_write = 1'b0;
        if (if_gnt) begin
            o_mem_addr = i_if_addr;
            o_mem_read = 1'b1;
        end else if (dm_gnt) begin
            o_mem_addr  = i_dm_addr;
            o_mem_data  = i_dm_wdata;
            o_mem_write = i_dm_we;
            o_mem_read  = ~i_dm_we;
        end
    end

    // Remember which port issued the read so its data can be steered one cycle later.
    always_comb begin
        rd_owner_next = RD_NONE;
        if (if_gnt) begin
            rd_owner_next = RD_FETCH;
        end else if (dm_gnt && !i_dm_we) begin
            rd_owner_next = RD_DATA;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rd_owner <= RD_NONE;
        end else begin
            rd_owner <= rd_owner_next;
        end
    end

    assign o_if_gnt    = if_gnt;
    assign o_dm_gnt    = dm_gnt;
    assign o_if_rvalid = (rd_owner == RD_FETCH);
    assign o_dm_rvalid = (rd_owner == RD_DATA);
    assign o_if_rdata  = i_mem_data;
    assign o_dm_rdata  = i_mem_data;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter with a behavioural arbitration and memory
// model; honours ROUND_ROBIN_EN when it is defined for the build.
module tb_mem_arbiter;
    localparam int W          = 32;
    localparam int D          = 8;
    localparam int STARVE_MAX = 3;

    logic         clk = 1'b0;
    logic         reset;
    logic         if_req;
    logic [D-1:0] if_addr;
    logic         if_gnt;
    logic         if_rvalid;
    logic [W-1:0] if_rdata;
    logic         dm_req;
    logic         dm_we;
    logic [D-1:0] dm_addr;
    logic [W-1:0] dm_wdata;
    logic         dm_gnt;
    logic         dm_rvalid;
    logic [W-1:0] dm_rdata;
    logic [D-1:0] mem_addr;
    logic [W-1:0] mem_data;
    logic         mem_read;
    logic         mem_write;
    logic [W-1:0] mem_q;

    logic         pl_en;
    logic [5:0]   pl_idx;
    logic [W-1:0] pl_val;
    logic [W-1:0] ram [0:63];

    int total = 0;
    int bad   = 0;

    logic [W-1:0] model_mem [0:63];
    int           m_waited;
    logic         m_last_fetch;
    logic         pend_if;
    logic         pend_dm;
    logic [W-1:0] pend_data;

    mem_arbiter #(.W(W), .D(D), .STARVE_MAX(STARVE_MAX)) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_if_req    (if_req),
        .i_if_addr   (if_addr),
        .o_if_gnt    (if_gnt),
        .o_if_rvalid (if_rvalid),
        .o_if_rdata  (if_rdata),
        .i_dm_req    (dm_req),
        .i_dm_we     (dm_we),
        .i_dm_addr   (dm_addr),
        .i_dm_wdata  (dm_wdata),
        .o_dm_gnt    (dm_gnt),
        .o_dm_rvalid (dm_rvalid),
        .o_dm_rdata  (dm_rdata),
        .o_mem_addr  (mem_addr),
        .o_mem_data  (mem_data),
        .o_mem_read  (mem_read),
        .o_mem_write (mem_write),
        .i_mem_data  (mem_q)
    );

    always #5 clk = ~clk;

    // Single-port synchronous word memory with a one-cycle read.
    always @(posedge clk) begin
        if (pl_en) begin
            ram[pl_idx] <= pl_val;
        end else begin
            if (mem_write) ram[mem_addr[7:2]] <= mem_data;
            if (mem_read)  mem_q <= ram[mem_addr[7:2]];
        end
    end

    function automatic void model_grant(output logic gi, output logic gd);
        gi = 1'b0;
        gd = 1'b0;
        if (reset) return;
        if (if_req && dm_req) begin
`ifdef ROUND_ROBIN_EN
            if (m_last_fetch) gd = 1'b1;
            else              gi = 1'b1;
`else
            if (m_waited >= STARVE_MAX) gi = 1'b1;
            else                        gd = 1'b1;
`endif
        end else begin
            gi = if_req;
            gd = dm_req;
        end
    endfunction

    // Advance the reference model across one rising edge, then step the clock.
    task automatic tick();
        logic gi, gd;
        model_grant(gi, gd);
        pend_if   = gi;
        pend_dm   = gd && !dm_we;
        pend_data = gi ? model_mem[if_addr[7:2]] : model_mem[dm_addr[7:2]];
        if (gd && dm_we) model_mem[dm_addr[7:2]] = dm_wdata;
        if (reset) begin
            m_waited     = 0;
            m_last_fetch = 1'b0;
        end else begin
            if (gi)      m_last_fetch = 1'b1;
            else if (gd) m_last_fetch = 1'b0;
            if (!if_req || gi)                    m_waited = 0;
            else if (gd && m_waited < STARVE_MAX) m_waited = m_waited + 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic preload();
        pl_en = 1'b1;
        for (int i = 0; i < 64; i++) begin
            pl_idx = 6'(i);
            pl_val = (i == 2) ? 32'hDEADBEEF : $urandom;
            model_mem[i] = pl_val;
            @(posedge clk);
            #1;
        end
        pl_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        if_req = 1'b0;
        dm_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) reset = 1'b0;
            @(negedge clk);
            total++;
            if ({if_gnt, dm_gnt, mem_read, mem_write, if_rvalid, dm_rvalid} !== 6'b0) begin
                bad++;
                $display("[TB] FAIL reset_idle cycle %0d got gnt/read/write/rvalid=%b want=000000", i,
                         {if_gnt, dm_gnt, mem_read, mem_write, if_rvalid, dm_rvalid});
            end
            tick();
        end
    endtask

    task automatic test_fetch_only();
        if_req  = 1'b1;
        if_addr = 8'h08;
        @(negedge clk);
        total++;
        if ({if_gnt, dm_gnt, mem_read, mem_write} !== 4'b1010 || mem_addr !== 8'h08) begin
            bad++;
            $display("[TB] FAIL fetch_issue got gnt/read/write=%b addr=%h want=1010 addr=08",
                     {if_gnt, dm_gnt, mem_read, mem_write}, mem_addr);
        end
        tick();
        if_req = 1'b0;
        @(negedge clk);
        total++;
        if ({if_rvalid, dm_rvalid} !== 2'b10 || if_rdata !== 32'hDEADBEEF) begin
            bad++;
            $display("[TB] FAIL fetch_return got rvalid=%b rdata=%h want=10 rdata=deadbeef",
                     {if_rvalid, dm_rvalid}, if_rdata);
        end
        tick();
    endtask

    task automatic test_write_read();
        dm_req   = 1'b1;
        dm_we    = 1'b1;
        dm_addr  = 8'h10;
        dm_wdata = 32'h12345678;
        @(negedge clk);
        total++;
        if ({dm_gnt, mem_read, mem_write} !== 3'b101 || mem_addr !== 8'h10 || mem_data !== 32'h12345678) begin
            bad++;
            $display("[TB] FAIL dm_write got gnt/read/write=%b addr=%h data=%h want=101 10 12345678",
                     {dm_gnt, mem_read, mem_write}, mem_addr, mem_data);
        end
        tick();
        dm_we = 1'b0;
        @(negedge clk);
        total++;
        if ({dm_gnt, mem_read, mem_write, if_rvalid, dm_rvalid} !== 5'b11000) begin
            bad++;
            $display("[TB] FAIL dm_read_issue got gnt/read/write/rvalid=%b want=11000",
                     {dm_gnt, mem_read, mem_write, if_rvalid, dm_rvalid});
        end
        tick();
        dm_req = 1'b0;
        @(negedge clk);
        total++;
        if ({if_rvalid, dm_rvalid} !== 2'b01 || dm_rdata !== 32'h12345678) begin
            bad++;
            $display("[TB] FAIL dm_read_return got rvalid=%b rdata=%h want=01 12345678",
                     {if_rvalid, dm_rvalid}, dm_rdata);
        end
        tick();
    endtask

    task automatic test_contention();
        logic [7:0] seq;
`ifdef ROUND_ROBIN_EN
        seq = 8'b0101_0101;
`else
        seq = 8'b1000_1000;
`endif
        reset = 1'b1;
        tick();
        reset    = 1'b0;
        if_req   = 1'b1;
        if_addr  = 8'h04;
        dm_req   = 1'b1;
        dm_we    = 1'b0;
        dm_addr  = 8'h20;
        for (int i = 0; i < 9; i++) begin
            if (i == 8) begin
                if_req = 1'b0;
                dm_req = 1'b0;
            end
            @(negedge clk);
            if (i < 8) begin
                total++;
                if ({if_gnt, dm_gnt} !== {seq[i], !seq[i]}) begin
                    bad++;
                    $display("[TB] FAIL contention_gnt step %0d got if/dm=%b want=%b", i,
                             {if_gnt, dm_gnt}, {seq[i], !seq[i]});
                end
            end
            if (i > 0) begin
                total++;
                if ({if_rvalid, dm_rvalid} !== {seq[i-1], !seq[i-1]} ||
                    (seq[i-1] ? if_rdata : dm_rdata) !== pend_data) begin
                    bad++;
                    $display("[TB] FAIL contention_rvalid step %0d got if/dm=%b data=%h want=%b data=%h", i,
                             {if_rvalid, dm_rvalid}, seq[i-1] ? if_rdata : dm_rdata,
                             {seq[i-1], !seq[i-1]}, pend_data);
                end
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_read();
        if_req  = 1'b1;
        if_addr = 8'h0C;
        dm_req  = 1'b0;
        @(negedge clk);
        total++;
        if (if_gnt !== 1'b1) begin
            bad++;
            $display("[TB] FAIL midreset_grant got if_gnt=%b want=1", if_gnt);
        end
        #1;
        reset = 1'b1;
        #1;
        total++;
        if ({if_gnt, dm_gnt, mem_read, mem_write} !== 4'b0) begin
            bad++;
            $display("[TB] FAIL midreset_gate got gnt/read/write=%b want=0000",
                     {if_gnt, dm_gnt, mem_read, mem_write});
        end
        tick();
        @(negedge clk);
        total++;
        if ({if_rvalid, dm_rvalid, if_gnt, mem_read} !== 4'b0) begin
            bad++;
            $display("[TB] FAIL midreset_rvalid got rvalid/gnt/read=%b want=0000",
                     {if_rvalid, dm_rvalid, if_gnt, mem_read});
        end
        tick();
        reset  = 1'b0;
        if_req = 1'b0;
        tick();
    endtask

    task automatic test_random();
        logic gi, gd;
        for (int c = 0; c < 400; c++) begin
            reset = ($urandom_range(0, 99) < 3);
            if (!if_req && $urandom_range(0, 99) < 60) begin
                if_req  = 1'b1;
                if_addr = 8'($urandom);
            end
            if (!dm_req && $urandom_range(0, 99) < 60) begin
                dm_req   = 1'b1;
                dm_we    = ($urandom_range(0, 1) == 1);
                dm_addr  = 8'($urandom);
                dm_wdata = $urandom;
            end
            @(negedge clk);
            model_grant(gi, gd);
            total++;
            if ({if_gnt, dm_gnt} !== {gi, gd}) begin
                bad++;
                $display("[TB] FAIL rand_gnt cycle %0d got if/dm=%b want=%b", c, {if_gnt, dm_gnt}, {gi, gd});
            end
            total++;
            if ({mem_read, mem_write} !== {gi || (gd && !dm_we), gd && dm_we} ||
                (gi && mem_addr !== if_addr) || (gd && mem_addr !== dm_addr) ||
                (gd && dm_we && mem_data !== dm_wdata)) begin
                bad++;
                $display("[TB] FAIL rand_mem cycle %0d got rd/wr=%b addr=%h data=%h want rd/wr=%b", c,
                         {mem_read, mem_write}, mem_addr, mem_data, {gi || (gd && !dm_we), gd && dm_we});
            end
            total++;
            if ({if_rvalid, dm_rvalid} !== {pend_if, pend_dm} ||
                (pend_if && if_rdata !== pend_data) || (pend_dm && dm_rdata !== pend_data)) begin
                bad++;
                $display("[TB] FAIL rand_rvalid cycle %0d got rvalid=%b if=%h dm=%h want rvalid=%b data=%h", c,
                         {if_rvalid, dm_rvalid}, if_rdata, dm_rdata, {pend_if, pend_dm}, pend_data);
            end
            tick();
            if (gi) if_req = 1'b0;
            if (gd) dm_req = 1'b0;
        end
        reset  = 1'b0;
        if_req = 1'b0;
        dm_req = 1'b0;
        tick();
    endtask

    initial begin
        reset        = 1'b1;
        if_req       = 1'b0;
        if_addr      = '0;
        dm_req       = 1'b0;
        dm_we        = 1'b0;
        dm_addr      = '0;
        dm_wdata     = '0;
        pl_en        = 1'b0;
        pl_idx       = '0;
        pl_val       = '0;
        m_waited     = 0;
        m_last_fetch = 1'b0;
        pend_if      = 1'b0;
        pend_dm      = 1'b0;
        pend_data    = '0;
        @(posedge clk);
        #1;
        preload();
        test_reset();
        test_fetch_only();
        test_write_read();
        test_contention();
        test_reset_mid_read();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
